fnd_sum_display: RTL
====================

// Module: fnd_sum_display
// PURPOSE
//  Downstream display stage of the 4-bit ripple adder. Captures the 5-bit result {cout,s3..s0}
//  on a valid strobe and time-multiplexes a 4-digit common-anode 7-seg (FND).
//  Digits 1:0 show the current sum in decimal (0..31); digits 3:2 show the previous sum.
//  Single clock domain; purely registered state, combinational segment decode.
// PARAMETERS
//  CLK_HZ   100_000_000  system clock frequency
//  SCAN_HZ  1_000        digit scan rate; DIV = CLK_HZ/SCAN_HZ clocks per digit, DIV >= 2 required
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous reset, active low
//  sum_valid  in   1  capture strobe, sampled every rising clk edge
//  sum        in   5  {cout,s3,s2,s1,s0} from the adder, unsigned 0..31
//  fnd_com    out  4  digit enables, active low, one-hot-low (bit0 = rightmost digit)
//  fnd_data   out  8  segments {dp,g,f,e,d,c,b,a}, active low
// BEHAVIOUR
//  Reset (async assert, sync release): cur=0, prev=0, cur_vld=0, prev_vld=0, div_cnt=0, scan=0;
//   outputs immediately fnd_com=4'b1110, fnd_data=8'hC0 ('0' on digit 0).
//  Capture: on sum_valid=1 at an edge: cur<=sum; cur_vld<=1; if cur_vld=1 then prev<=cur and
//   prev_vld<=1. Back-to-back strobes each capture; new values are visible on the outputs
//   the cycle after the capture edge, on whichever digit is being scanned.
//  Prescaler: div_cnt counts 0..DIV-1 and wraps; on div_cnt==DIV-1, scan<=scan+1 (2-bit wrap 3->0).
//   Each digit is lit for exactly DIV cycles; full frame = 4*DIV cycles.
//  fnd_com = ~(4'b0001 << scan); it changes on the same edge as scan.
//  Digit content (value v: tens = v/10, units = v%10):
//   scan0: units(cur)                       - always shown ('0' before the first capture)
//   scan1: tens(cur), blank if cur<10
//   scan2: units(prev) with dp lit          - blank (8'hFF, no dp) while prev_vld=0
//   scan3: tens(prev), blank if prev<10 or prev_vld=0
//  Segment codes: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90; blank=FF; dp lit clears bit 7.
//  Arithmetic: v in 0..31, so tens is 0..3; there is no overflow path. Bits above [4:0] do not exist.
//  sum is sampled only when sum_valid=1; sum is don't-care otherwise.
//  Reset mid-frame: scan, the digit registers and the valid flags clear immediately; there is no
//   partial-frame recovery.
// STRUCTURE
//  Shared package: segment constants SEG_0..SEG_9, SEG_BLANK, DP_MASK (8'h7F).
//  One sub-module: fnd_seg_decoder (4-bit digit + blank + dp_on -> 8-bit active-low segments).
//   It is purely combinational and is instantiated once, driven by a digit mux on scan.
//  Top level holds the capture registers, prescaler, scan counter, binary->tens/units and the mux.
// TESTING  (CLK_HZ=40, SCAN_HZ=10 -> DIV=4)
//  1 Reset at t=0, then idle: frame of 16 clks -> fnd_com 1110/1101/1011/0111, 4 clks each;
//    fnd_data C0,FF,FF,FF.
//  2 sum_valid=1, sum=23 for 1 clk -> digit0 B0, digit1 A4, digit2 FF, digit3 FF (prev not yet valid).
//  3 Then sum_valid=1, sum=31 -> digit0 F9, digit1 B0, digit2 30 (3 with dp), digit3 A4.
//  4 From reset: strobes on consecutive clks with sum=5 then sum=9 -> digit0 90, digit1 FF,
//    digit2 12, digit3 FF.
//  5 sum=10 then sum=0 -> digit0 C0, digit1 FF, digit2 40 ('0'+dp), digit3 F9; checks zero blanking.
//  6 rst_n pulled low mid-digit-2 after test 3 -> same cycle fnd_com=1110, fnd_data=C0;
//    next frame shows 0 with digits 3:1 blank.

Source files
------------

// File: rtl/fnd_sum_display_pkg.sv
// Shared constants and helpers for the adder-result FND display.
package fnd_sum_display_pkg;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] DP_MASK   = 8'h7F;

    // Scan positions, rightmost digit first
    localparam logic [1:0] SCAN_CUR_U = 2'd0;
    localparam logic [1:0] SCAN_CUR_T = 2'd1;
    localparam logic [1:0] SCAN_PRV_U = 2'd2;
    localparam logic [1:0] SCAN_PRV_T = 2'd3;

    // Tens digit of a 0..31 value (0..3)
    function automatic logic [1:0] tens_of(input logic [4:0] v);
        if (v >= 5'd30) return 2'd3;
        if (v >= 5'd20) return 2'd2;
        if (v >= 5'd10) return 2'd1;
        return 2'd0;
    endfunction

    // Units digit of a 0..31 value (0..9)
    function automatic logic [3:0] units_of(input logic [4:0] v);
        case (tens_of(v))
            2'd3:    return 4'(v - 5'd30);
            2'd2:    return 4'(v - 5'd20);
            2'd1:    return 4'(v - 5'd10);
            default: return 4'(v);
        endcase
    endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Decimal digit to active-low 7-segment pattern with blanking and decimal point.
module fnd_seg_decoder
    import fnd_sum_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dp_on,
    output logic [7:0] seg_c
);

    // Blank wins over dp so an unused digit stays fully dark
    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
            if (dp_on) seg_c = seg_c & DP_MASK;
        end
    end

endmodule

// File: rtl/fnd_sum_display.sv
// Captures the adder result and scans current/previous sums onto a 4-digit FND.
module fnd_sum_display
    import fnd_sum_display_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sum_valid,
    input  logic [4:0] sum,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [4:0]       cur_q,     cur_d;
    logic [4:0]       prev_q,    prev_d;
    logic             cur_vld_q, cur_vld_d;
    logic             prev_vld_q, prev_vld_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       scan_q,    scan_d;

    logic [3:0]       dig_c;
    logic             blank_c;
    logic             dp_c;

    // Capture, prescaler and scan next-state
    always_comb begin
        cur_d      = cur_q;
        prev_d     = prev_q;
        cur_vld_d  = cur_vld_q;
        prev_vld_d = prev_vld_q;
        div_cnt_d  = div_cnt_q + DIV_W'(1);
        scan_d     = scan_q;

        if (sum_valid) begin
            cur_d     = sum;
            cur_vld_d = 1'b1;
            if (cur_vld_q) begin
                prev_d     = cur_q;
                prev_vld_d = 1'b1;
            end
        end

        if (div_cnt_q == DIV_W'(DIV - 1)) begin
            div_cnt_d = '0;
            scan_d    = scan_q + 2'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q      <= '0;
            prev_q     <= '0;
            cur_vld_q  <= 1'b0;
            prev_vld_q <= 1'b0;
            div_cnt_q  <= '0;
            scan_q     <= SCAN_CUR_U;
        end else begin
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            cur_vld_q  <= cur_vld_d;
            prev_vld_q <= prev_vld_d;
            div_cnt_q  <= div_cnt_d;
            scan_q     <= scan_d;
        end
    end

    // Digit selection for the position being scanned
    always_comb begin
        dig_c   = '0;
        blank_c = 1'b0;
        dp_c    = 1'b0;
        case (scan_q)
            SCAN_CUR_U: begin
                dig_c = units_of(cur_q);
            end
            SCAN_CUR_T: begin
                dig_c   = {2'b00, tens_of(cur_q)};
                blank_c = (cur_q < 5'd10);
            end
            SCAN_PRV_U: begin
                dig_c   = units_of(prev_q);
                blank_c = !prev_vld_q;
                dp_c    = prev_vld_q;
            end
            default: begin
                dig_c   = {2'b00, tens_of(prev_q)};
                blank_c = !prev_vld_q || (prev_q < 5'd10);
            end
        endcase
    end

    fnd_seg_decoder u_dec (
        .digit (dig_c),
        .blank (blank_c),
        .dp_on (dp_c),
        .seg_c (fnd_data)
    );

    // One-hot-low digit enable follows the scan register directly
    assign fnd_com = ~(4'b0001 << scan_q);

endmodule
